ascon_round_ctrl: RTL and testbench
===================================

# ascon_round_ctrl

Control FSM for the ASCON-128 encryption datapath: sequences the p12/p6 permutation rounds, the key, data and domain-separation XOR points, and the plaintext-block handshake. It is the driver side of the 2-bit block counter: it issues the counter's `en_i`/`init_a_i` and reads its count back to detect the last block. Sits between the top-level command interface and the permutation/state-register datapath.

## Interface
- `NB_BLOCKS`, default 4: number of plaintext blocks per message. Legal range 1..4, matching the 2-bit block counter range.

- `clock_i` in 1: clock, rising edge.
- `resetb_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: start one encryption. Sampled only in IDLE.
- `data_valid_i` in 1: plaintext block present on the datapath data bus.
- `block_cnt_i` in 2: current block index from the block counter.
- `data_ready_o` out 1: controller accepts a plaintext block.
- `data_load_o` out 1: load the datapath data register.
- `round_o` out 4: round index for constant addition (0..11).
- `perm_en_o` out 1: state register captures the permutation round output.
- `sel_init_o` out 1: permutation input mux selects IV||K||N.
- `xor_data_o` out 1: XOR the data register into state at the permutation input.
- `xor_key_begin_o` out 1: XOR the key at the permutation input.
- `xor_key_end_o` out 1: XOR the key at the permutation output.
- `xor_lsb_end_o` out 1: XOR domain separation bit 1 at the permutation output.
- `block_en_o` out 1: drives the block counter `en_i`.
- `block_init_o` out 1: drives the block counter `init_a_i`.
- `cipher_valid_o` out 1: ciphertext block valid on the datapath output.
- `tag_valid_o` out 1: tag valid on the datapath output.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle end-of-message pulse.

## Operation
- States:
  - IDLE
  - INIT: p12, round 0..11
  - AD: p6, round 6..11
  - WAIT: block handshake
  - PT: p6, round 6..11
  - FINAL: p12, round 0..11
  - DONE
- Internal 4-bit round counter drives `round_o`.
  - Entering INIT or FINAL: counter loads 0.
  - Entering AD or PT: counter loads 6.
  - Increments by 1 each cycle in INIT/AD/PT/FINAL. The last round is always 11, with no wrap.
- IDLE, `start_i=1` → INIT. In the same cycle:
  - `data_load_o=1` captures the associated-data block.
  - `block_en_o=1` and `block_init_o=1` clear the block counter.
- INIT:
  - `perm_en_o=1` on every round.
  - `sel_init_o=1` on round 0.
  - `xor_key_end_o=1` on round 11.
  - After round 11 → AD.
- AD:
  - `perm_en_o=1` on every round.
  - `xor_data_o=1` on round 6.
  - `xor_lsb_end_o=1` on round 11.
  - After round 11 → WAIT.
- WAIT: `data_ready_o=1`, `perm_en_o=0`. On `data_valid_i=1`:
  - `data_load_o=1` and `cipher_valid_o=1` in the same cycle.
  - If `block_cnt_i == NB_BLOCKS-1` → FINAL; otherwise → PT.
  - With `data_valid_i=0`, the controller stays in WAIT indefinitely with state held.
- PT:
  - `perm_en_o=1` on every round.
  - `xor_data_o=1` on round 6.
  - Round 11: `block_en_o=1`, `block_init_o=0` (counter increments).
  - After round 11 → WAIT.
- FINAL:
  - `perm_en_o=1` on every round.
  - Round 0: `xor_data_o=1` and `xor_key_begin_o=1`.
  - Round 11: `xor_key_end_o=1`.
  - After round 11 → DONE.
- DONE: `tag_valid_o=1` and `done_o=1` for one cycle, then → IDLE.
- `start_i` is ignored in every state except IDLE. `data_valid_i` is ignored outside WAIT.
- Output timing:
  - `data_load_o` and `cipher_valid_o` are combinational from state and `data_valid_i`.
  - `block_en_o` and `block_init_o` in the IDLE start cycle depend on `start_i`.
  - All other outputs decode from state and round only.

## Timing
- Reset: `resetb_i=0` at a rising edge puts the FSM in IDLE and the round counter at 0, whatever the current state, including mid-round. All outputs read 0 while in IDLE.
- Start accept cycle = cycle 0.
  - INIT occupies cycles 1–12.
  - AD occupies cycles 13–18.
  - The first WAIT is cycle 19.
- Each non-final block costs 1 WAIT cycle plus 6 PT cycles with no stall. The final block costs 1 WAIT cycle plus 12 FINAL cycles.
- With `NB_BLOCKS=4` and `data_valid_i` held high, `done_o` asserts at cycle 53. With `NB_BLOCKS=1`, it asserts at cycle 32.
- Each WAIT stall cycle delays `done_o` by exactly 1 cycle.
- `start_i` held high in DONE does not start a new message. A new start can be accepted on the first IDLE cycle after DONE.

## Test plan
- Reset, then `start_i` pulse, `data_valid_i=1` constant, `NB_BLOCKS=4`, `block_cnt_i` fed from a real block counter:
  - `done_o` and `tag_valid_o` at cycle 53.
  - `cipher_valid_o` at cycles 19, 26, 33, 40.
  - `round_o` sequence 0..11, 6..11, then (6..11)×3, 0..11.
- Same with `NB_BLOCKS=1`:
  - Single `cipher_valid_o` at cycle 19.
  - FINAL at cycles 20–31; `done_o` at cycle 32.
  - `block_en_o` asserted only in cycle 0.
- `data_valid_i` low for 5 cycles in the second WAIT:
  - `data_ready_o` stays high and `perm_en_o` stays 0 throughout.
  - `done_o` shifts to cycle 58.
- `start_i` pulsed during INIT round 4 and again in DONE: no effect; the sequence and `done_o` timing are unchanged.
- `resetb_i=0` for one cycle during PT round 8:
  - Next cycle is IDLE with all outputs 0 and `round_o=0`.
  - A fresh start then completes normally.
- XOR strobe check over a full message:
  - `sel_init_o` in cycle 1 only.
  - `xor_key_end_o` in cycles 12 and 52.
  - `xor_lsb_end_o` in cycle 18.
  - `xor_key_begin_o` in cycle 41.

Source files
------------

// File: rtl/ascon_round_ctrl.sv
// Round/phase sequencer for the ASCON-128 encryption datapath: walks the
// p12/p6 permutations, strobes the XOR points and handshakes plaintext blocks.
module ascon_round_ctrl #(
  parameter int NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [1:0] block_cnt_i,
  output logic       data_ready_o,
  output logic       data_load_o,
  output logic [3:0] round_o,
  output logic       perm_en_o,
  output logic       sel_init_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_end_o,
  output logic       block_en_o,
  output logic       block_init_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_WAIT  = 3'd3,
    S_PT    = 3'd4,
    S_FINAL = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] LAST_BLK = 2'(NB_BLOCKS - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       last_round;

  assign last_round  = (round_q == 4'd11);
  assign round_o     = round_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Handshake: a plaintext block transfers in a cycle where data_ready_o and
  // data_valid_i are both high; ready is raised only in WAIT, and ready with
  // valid low simply holds the controller in WAIT.
  always_comb begin
    state_d         = state_q;
    round_d         = round_q;
    data_ready_o    = 1'b0;
    data_load_o     = 1'b0;
    perm_en_o       = 1'b0;
    sel_init_o      = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_end_o   = 1'b0;
    block_en_o      = 1'b0;
    block_init_o    = 1'b0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    done_o          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          data_load_o  = 1'b1;
          block_en_o   = 1'b1;
          block_init_o = 1'b1;
          state_d      = S_INIT;
          round_d      = 4'd0;
        end
      end
      S_INIT: begin
        perm_en_o     = 1'b1;
        sel_init_o    = (round_q == 4'd0);
        xor_key_end_o = last_round;
        if (last_round) begin
          state_d = S_AD;
          round_d = 4'd6;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_AD: begin
        perm_en_o     = 1'b1;
        xor_data_o    = (round_q == 4'd6);
        xor_lsb_end_o = last_round;
        if (last_round) state_d = S_WAIT;
        else            round_d = round_q + 4'd1;
      end
      S_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          data_load_o    = 1'b1;
          cipher_valid_o = 1'b1;
          if (block_cnt_i == LAST_BLK) begin
            state_d = S_FINAL;
            round_d = 4'd0;
          end else begin
            state_d = S_PT;
            round_d = 4'd6;
          end
        end
      end
      S_PT: begin
        perm_en_o  = 1'b1;
        xor_data_o = (round_q == 4'd6);
        block_en_o = last_round;
        if (last_round) state_d = S_WAIT;
        else            round_d = round_q + 4'd1;
      end
      S_FINAL: begin
        perm_en_o       = 1'b1;
        xor_data_o      = (round_q == 4'd0);
        xor_key_begin_o = (round_q == 4'd0);
        xor_key_end_o   = last_round;
        if (last_round) begin
          state_d = S_DONE;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = S_IDLE;
        round_d     = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: NB_BLOCKS=4 and NB_BLOCKS=1 instances, each fed by
// its own block counter, checked every cycle against a queue-based phase model.
module tb_ascon_round_ctrl;

  typedef enum int {K_IDLE, K_INIT, K_AD, K_WAIT, K_PT, K_FINAL, K_DONE} kind_t;
  typedef struct { kind_t kind; int rnd; } desc_t;
  typedef struct {
    int nb_idx; int stall_wait; int stall_len; int noise;
    int exp_done; int exp_cv_first;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb;
  logic [1:0] start_v, dv_v;
  logic [1:0] cnt [2];

  logic [1:0] rdy_w, load_w, perm_w, sel_w, xd_w, kb_w, ke_w, lsb_w;
  logic [1:0] ben_w, bini_w, cv_w, tv_w, busy_w, done_w;
  logic [3:0] round_w [2];
  logic [2:0] dbg_w [2];

  ascon_round_ctrl #(.NB_BLOCKS(4)) u_dut4 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_v[0]), .data_valid_i(dv_v[0]),
    .block_cnt_i(cnt[0]), .data_ready_o(rdy_w[0]), .data_load_o(load_w[0]),
    .round_o(round_w[0]), .perm_en_o(perm_w[0]), .sel_init_o(sel_w[0]),
    .xor_data_o(xd_w[0]), .xor_key_begin_o(kb_w[0]), .xor_key_end_o(ke_w[0]),
    .xor_lsb_end_o(lsb_w[0]), .block_en_o(ben_w[0]), .block_init_o(bini_w[0]),
    .cipher_valid_o(cv_w[0]), .tag_valid_o(tv_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .dbg_state_o(dbg_w[0])
  );

  ascon_round_ctrl #(.NB_BLOCKS(1)) u_dut1 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_v[1]), .data_valid_i(dv_v[1]),
    .block_cnt_i(cnt[1]), .data_ready_o(rdy_w[1]), .data_load_o(load_w[1]),
    .round_o(round_w[1]), .perm_en_o(perm_w[1]), .sel_init_o(sel_w[1]),
    .xor_data_o(xd_w[1]), .xor_key_begin_o(kb_w[1]), .xor_key_end_o(ke_w[1]),
    .xor_lsb_end_o(lsb_w[1]), .block_en_o(ben_w[1]), .block_init_o(bini_w[1]),
    .cipher_valid_o(cv_w[1]), .tag_valid_o(tv_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .dbg_state_o(dbg_w[1])
  );

  // Real 2-bit block counters driven by the controllers.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetb)          cnt[d] <= 2'd0;
      else if (ben_w[d])    cnt[d] <= bini_w[d] ? 2'd0 : cnt[d] + 2'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  kind_t cur_k [2];
  int    cur_r [2];
  desc_t pend [2][$];
  int    blocks [2];
  int    nb [2] = '{4, 1};

  function automatic void push_one(input int d, input kind_t k, input int r);
    desc_t e;
    e.kind = k;
    e.rnd  = r;
    pend[d].push_back(e);
  endfunction

  function automatic void push_rounds(input int d, input kind_t k, input int lo);
    for (int r = lo; r <= 11; r++) push_one(d, k, r);
  endfunction

  function automatic void model_advance(input int d);
    desc_t e;
    if (!resetb) begin
      cur_k[d] = K_IDLE;
      cur_r[d] = 0;
      pend[d].delete();
      return;
    end
    case (cur_k[d])
      K_IDLE: if (start_v[d]) begin
        blocks[d] = 0;
        push_rounds(d, K_INIT, 0);
        push_rounds(d, K_AD, 6);
        push_one(d, K_WAIT, 11);
      end
      K_WAIT: if (dv_v[d]) begin
        blocks[d]++;
        if (blocks[d] == nb[d]) begin
          push_rounds(d, K_FINAL, 0);
          push_one(d, K_DONE, 0);
        end else begin
          push_rounds(d, K_PT, 6);
          push_one(d, K_WAIT, 11);
        end
      end
      K_DONE: push_one(d, K_IDLE, 0);
      default: ;
    endcase
    if (pend[d].size() > 0) begin
      e = pend[d].pop_front();
      cur_k[d] = e.kind;
      cur_r[d] = e.rnd;
    end
  endfunction

  function automatic logic [13:0] exp_outs(input int d);
    kind_t k = cur_k[d];
    int    r = cur_r[d];
    logic  s = start_v[d];
    logic  v = dv_v[d];
    logic  go = (k == K_IDLE) && s;
    logic  acc = (k == K_WAIT) && v;
    logic  perm = (k == K_INIT) || (k == K_AD) || (k == K_PT) || (k == K_FINAL);
    return {k != K_IDLE, k == K_WAIT, go || acc, acc, perm,
            k == K_INIT && r == 0,
            ((k == K_AD || k == K_PT) && r == 6) || (k == K_FINAL && r == 0),
            k == K_FINAL && r == 0,
            (k == K_INIT || k == K_FINAL) && r == 11,
            k == K_AD && r == 11,
            go || (k == K_PT && r == 11),
            go,
            k == K_DONE, k == K_DONE};
  endfunction

  function automatic logic [13:0] act_outs(input int d);
    return {busy_w[d], rdy_w[d], load_w[d], cv_w[d], perm_w[d], sel_w[d], xd_w[d],
            kb_w[d], ke_w[d], lsb_w[d], ben_w[d], bini_w[d], tv_w[d], done_w[d]};
  endfunction

  // ---------------- driver ----------------
  int act_d;
  int mcyc;
  int obs_done;
  int cv_q[$], sel_q[$], ke_q[$], lsb_q[$], kb_q[$];

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("nb%0d_outs", nb[d]), 32'(act_outs(d)), 32'(exp_outs(d)));
      if (cur_k[d] != K_WAIT && cur_k[d] != K_DONE)
        check($sformatf("nb%0d_round", nb[d]), 32'(round_w[d]), 32'(cur_r[d]));
    end
    if (done_w[act_d] && obs_done < 0) obs_done = mcyc;
    if (cv_w[act_d])  cv_q.push_back(mcyc);
    if (sel_w[act_d]) sel_q.push_back(mcyc);
    if (ke_w[act_d])  ke_q.push_back(mcyc);
    if (lsb_w[act_d]) lsb_q.push_back(mcyc);
    if (kb_w[act_d])  kb_q.push_back(mcyc);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_advance(d);
    #1;
    mcyc++;
  endtask

  task automatic run_msg(input int d, input int stall_wait, input int stall_len,
                         input int noise);
    int    waits = 0;
    int    stalled = 0;
    kind_t prev = K_IDLE;
    act_d = d;
    mcyc = 0;
    obs_done = -1;
    cv_q.delete(); sel_q.delete(); ke_q.delete(); lsb_q.delete(); kb_q.delete();
    start_v[d] = 1'b1;
    dv_v[d] = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    start_v[d] = 1'b0;
    for (int n = 0; n < 300 && obs_done < 0; n++) begin
      if (cur_k[d] == K_WAIT && prev != K_WAIT) waits++;
      prev = cur_k[d];
      if (cur_k[d] == K_WAIT) begin
        if (waits == stall_wait && stalled < stall_len) begin
          dv_v[d] = 1'b0;
          stalled++;
        end else begin
          dv_v[d] = 1'b1;
        end
      end else begin
        dv_v[d] = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start_v[d] = (noise != 0) &&
                   ((cur_k[d] == K_INIT && cur_r[d] == 4) || cur_k[d] == K_DONE);
      step();
    end
    start_v[d] = 1'b0;
    dv_v[d] = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [6];
  int   base_done [2] = '{53, 32};

  initial begin
    vecs[0] = '{nb_idx: 0, stall_wait: 0, stall_len: 0, noise: 0, exp_done: 53, exp_cv_first: 19};
    vecs[1] = '{nb_idx: 1, stall_wait: 0, stall_len: 0, noise: 0, exp_done: 32, exp_cv_first: 19};
    vecs[2] = '{nb_idx: 0, stall_wait: 2, stall_len: 5, noise: 0, exp_done: 58, exp_cv_first: 19};
    vecs[3] = '{nb_idx: 0, stall_wait: 0, stall_len: 0, noise: 1, exp_done: 53, exp_cv_first: 19};
    vecs[4] = '{nb_idx: 1, stall_wait: 1, stall_len: 3, noise: 1, exp_done: 35, exp_cv_first: 22};
    vecs[5] = '{nb_idx: 0, stall_wait: 4, stall_len: 2, noise: 0, exp_done: 55, exp_cv_first: 19};

    resetb  = 1'b0;
    start_v = 2'b00;
    dv_v    = 2'b00;
    act_d   = 0;
    for (int d = 0; d < 2; d++) begin
      cur_k[d] = K_IDLE;
      cur_r[d] = 0;
      blocks[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    step();
    step();

    // Table-driven messages.
    for (int i = 0; i < 6; i++) begin
      run_msg(vecs[i].nb_idx, vecs[i].stall_wait, vecs[i].stall_len, vecs[i].noise);
      check($sformatf("v%0d_done_cycle", i), 32'(obs_done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_cv_count", i), 32'(cv_q.size()), 32'(nb[vecs[i].nb_idx]));
      if (cv_q.size() > 0)
        check($sformatf("v%0d_cv_first", i), 32'(cv_q[0]), 32'(vecs[i].exp_cv_first));
      if (vecs[i].stall_len == 0) begin
        for (int k = 1; k < cv_q.size(); k++)
          check($sformatf("v%0d_cv_%0d", i, k), 32'(cv_q[k]), 32'(19 + 7 * k));
        check($sformatf("v%0d_sel_init", i), 32'(sel_q.size() == 1 && sel_q[0] == 1), 32'd1);
        check($sformatf("v%0d_key_end", i),
              32'(ke_q.size() == 2 && ke_q[0] == 12 && ke_q[1] == vecs[i].exp_done - 1), 32'd1);
        check($sformatf("v%0d_lsb_end", i), 32'(lsb_q.size() == 1 && lsb_q[0] == 18), 32'd1);
        check($sformatf("v%0d_key_begin", i),
              32'(kb_q.size() == 1 && kb_q[0] == vecs[i].exp_done - 12), 32'd1);
      end
      step();
    end

    // Reset during PT round 8, then a fresh message.
    act_d = 0;
    start_v[0] = 1'b1;
    dv_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int n = 0; n < 100 && !(cur_k[0] == K_PT && cur_r[0] == 8); n++) step();
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    dv_v[0] = 1'b0;
    check("rst_mid_pt_outs", 32'(act_outs(0)), 32'd0);
    check("rst_mid_pt_round", 32'(round_w[0]), 32'd0);
    step();
    run_msg(0, 0, 0, 0);
    check("after_rst_done_cycle", 32'(obs_done), 32'd53);
    step();

    // Randomized messages against the model.
    for (int i = 0; i < 8; i++) begin
      int d  = int'($urandom_range(0, 1));
      int sw = int'($urandom_range(1, nb[d]));
      int sl = int'($urandom_range(0, 6));
      run_msg(d, sw, sl, 1);
      check($sformatf("rnd%0d_done_cycle", i), 32'(obs_done), 32'(base_done[d] + sl));
      repeat ($urandom_range(1, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
